// File: rtl/fa_cache_pkg.sv
// fa_cache_pkg
//   Shared constants, geometry helpers and the line record for the fully
//   associative cache.
//   - ADDR_W / DATA_W : byte-address width and data width.
//   - offset_w()      : number of byte-offset bits for a given line size.
//   - tag_w()         : number of tag bits for a given line size.
//   - way_w()         : width of a way index (at least 1 bit).
//   - line_t          : valid bit, tag and data bytes of one line.
//   line_t is sized for the largest supported line (MAX_BLOCK_SIZE bytes) and
//   a full-width tag. A cache instance zero-extends its tag into the field and
//   zero-fills the unused bytes. Those constant bits are trimmed away when the
//   design is built.
package fa_cache_pkg;

    localparam int ADDR_W         = 32;
    localparam int DATA_W         = 8;
    localparam int MAX_BLOCK_SIZE = 64;
    localparam int MAX_OFFSET_W   = 6;

    function automatic int offset_w(input int block_size);
        return $clog2(block_size);
    endfunction

    function automatic int tag_w(input int block_size);
        return ADDR_W - $clog2(block_size);
    endfunction

    function automatic int way_w(input int assoc);
        return (assoc > 1) ? $clog2(assoc) : 1;
    endfunction

    typedef logic [DATA_W-1:0] byte_t;

    typedef struct packed {
        logic                             valid;
        logic [ADDR_W-1:0]                tag;
        byte_t [MAX_BLOCK_SIZE-1:0]       data;
    } line_t;

endpackage

// File: rtl/fa_cache_replace.sv
// fa_cache_replace
//   Victim selection for the fully associative cache.
//   Default build: a FIFO pointer that advances on every allocation.
//   With FA_CACHE_LRU_EN defined, the victim is the lowest-index invalid line
//   if one exists. Otherwise it is the least-recently-used line. A hit or an
//   allocation makes the touched line the most recent one.
//   Ports:
//     clk, srst          - clock, synchronous active-high reset
//     alloc              - this edge allocates the current victim
//     hit, hit_way       - (LRU only) this edge hits in way hit_way
//     valid              - (LRU only) per-way valid bits
//     victim             - way to allocate on a miss
module fa_cache_replace
    import fa_cache_pkg::*;
#(
    parameter int ASSOC = 16,
    parameter int WAY_W = way_w(ASSOC)
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             alloc,
`ifdef FA_CACHE_LRU_EN
    input  logic             hit,
    input  logic [WAY_W-1:0] hit_way,
    input  logic [ASSOC-1:0] valid,
`endif
    output logic [WAY_W-1:0] victim
);

`ifdef FA_CACHE_LRU_EN
    // rank_reg[w] is the recency rank of way w: 0 = least recent,
    // ASSOC-1 = most recent. The ranks always form a permutation.
    logic [WAY_W-1:0] rank_reg  [ASSOC];
    logic [WAY_W-1:0] rank_next [ASSOC];
    logic [WAY_W-1:0] inv_way;
    logic [WAY_W-1:0] lru_way;
    logic             inv_found;
    logic             touch;
    logic [WAY_W-1:0] touch_way;

    always_comb begin
        inv_way   = '0;
        inv_found = 1'b0;
        lru_way   = '0;
        // Scan downward so the lowest invalid index wins.
        for (int w = ASSOC - 1; w >= 0; w--) begin
            if (!valid[w]) begin
                inv_way   = WAY_W'(w);
                inv_found = 1'b1;
            end
            if (rank_reg[w] == '0) begin
                lru_way = WAY_W'(w);
            end
        end
    end

    assign victim    = inv_found ? inv_way : lru_way;
    assign touch     = hit | alloc;
    assign touch_way = hit ? hit_way : victim;

    generate
        for (genvar gi = 0; gi < ASSOC; gi++) begin : g_rank
            always_comb begin
                rank_next[gi] = rank_reg[gi];
                if (touch) begin
                    if (touch_way == WAY_W'(gi)) begin
                        rank_next[gi] = WAY_W'(ASSOC - 1);
                    end else if (rank_reg[gi] > rank_reg[touch_way]) begin
                        rank_next[gi] = rank_reg[gi] - 1'b1;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (srst) begin
                    rank_reg[gi] <= WAY_W'(gi);
                end else begin
                    rank_reg[gi] <= rank_next[gi];
                end
            end
        end
    endgenerate
`else
    logic [WAY_W-1:0] ptr_reg;
    logic [WAY_W-1:0] ptr_next;

    always_comb begin
        ptr_next = ptr_reg;
        if (alloc) begin
            ptr_next = (ptr_reg == WAY_W'(ASSOC - 1)) ? '0 : ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

    assign victim = ptr_reg;
`endif

endmodule

// File: rtl/fully_associative_cache.sv
// fully_associative_cache
//   Byte-addressed fully associative cache. Every rising clk edge without
//   reset is one access. The tag is compared against all valid lines in
//   parallel. A miss allocates the victim line for both reads and writes:
//   the line is made valid, gets the new tag and has all its bytes zeroed.
//   hit, miss and rd_data are registered and describe the previous access.
//   Optional build macro FA_CACHE_LRU_EN selects LRU replacement instead of
//   FIFO replacement (see fa_cache_replace).
//   Ports:
//     clk      - clock
//     reset    - synchronous active-high reset
//     addr     - byte address (tag = addr[31:OFFSET_W])
//     wr_data  - byte to write
//     wr_en    - 1 = write access, 0 = read access
//     rd_data  - registered read data (wr_data on writes, 0 on read miss)
//     hit/miss - registered result of the previous access
module fully_associative_cache
    import fa_cache_pkg::*;
#(
    parameter int CACHE_SIZE = 256,
    parameter int BLOCK_SIZE = 16,
    parameter int ASSOC      = CACHE_SIZE / BLOCK_SIZE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              hit,
    output logic              miss
);

    localparam int OFFSET_W = offset_w(BLOCK_SIZE);
    localparam int TAG_W    = tag_w(BLOCK_SIZE);
    localparam int WAY_W    = way_w(ASSOC);

    line_t                     lines_reg [ASSOC];
    logic [ASSOC-1:0]          valid_vec;
    logic [ASSOC-1:0]          hit_vec;
    logic                      hit_any;
    logic [WAY_W-1:0]          hit_way;
    logic [WAY_W-1:0]          victim;
    logic                      alloc;
    logic [TAG_W-1:0]          req_tag;
    logic [MAX_OFFSET_W-1:0]   req_off;
    byte_t [MAX_BLOCK_SIZE-1:0] fill_data;
    logic                      hit_reg;
    logic                      miss_reg;
    logic [DATA_W-1:0]         rd_data_reg;

    assign req_tag = addr[ADDR_W-1:OFFSET_W];
    assign req_off = MAX_OFFSET_W'(addr[OFFSET_W-1:0]);

    generate
        for (genvar gi = 0; gi < ASSOC; gi++) begin : g_cmp
            assign valid_vec[gi] = lines_reg[gi].valid;
            assign hit_vec[gi]   = lines_reg[gi].valid &&
                                   (lines_reg[gi].tag == ADDR_W'(req_tag));
        end
    endgenerate

    assign hit_any = |hit_vec;

    // At most one way matches because a tag is only allocated on a miss.
    always_comb begin
        hit_way = '0;
        for (int w = 0; w < ASSOC; w++) begin
            if (hit_vec[w]) begin
                hit_way = WAY_W'(w);
            end
        end
    end

    // Contents of a freshly allocated line: zeros, plus the written byte on
    // a write miss.
    always_comb begin
        fill_data = '0;
        if (wr_en) begin
            fill_data[req_off] = wr_data;
        end
    end

    assign alloc = ~reset & ~hit_any;

    fa_cache_replace #(
        .ASSOC   (ASSOC),
        .WAY_W   (WAY_W)
    ) u_replace (
        .clk     (clk),
        .srst    (reset),
        .alloc   (alloc),
`ifdef FA_CACHE_LRU_EN
        .hit     (hit_any),
        .hit_way (hit_way),
        .valid   (valid_vec),
`endif
        .victim  (victim)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int w = 0; w < ASSOC; w++) begin
                lines_reg[w].valid <= 1'b0;
            end
            hit_reg     <= 1'b0;
            miss_reg    <= 1'b0;
            rd_data_reg <= '0;
        end else begin
            hit_reg  <= hit_any;
            miss_reg <= ~hit_any;
            if (hit_any) begin
                if (wr_en) begin
                    lines_reg[hit_way].data[req_off] <= wr_data;
                    rd_data_reg                      <= wr_data;
                end else begin
                    rd_data_reg <= lines_reg[hit_way].data[req_off];
                end
            end else begin
                lines_reg[victim].valid <= 1'b1;
                lines_reg[victim].tag   <= ADDR_W'(req_tag);
                lines_reg[victim].data  <= fill_data;
                rd_data_reg             <= wr_en ? wr_data : '0;
            end
        end
    end

    // Keeps the valid vector referenced in builds where replacement ignores it.
    logic unused_ok;
    assign unused_ok = &{1'b0, valid_vec};

    assign hit     = hit_reg;
    assign miss    = miss_reg;
    assign rd_data = rd_data_reg;

endmodule

// File: tb/tb_fully_associative_cache.sv
// tb_fully_associative_cache
//   Bench for fully_associative_cache with its default geometry
//   (16 lines of 16 bytes). It applies a table of directed vectors with
//   fixed expected values. It then runs hand sequences for reset and
//   repeated addresses. Last, it runs random accesses that are checked
//   against a tag-lookup reference model.
module tb_fully_associative_cache;

    localparam int NW = 16;
    localparam int BS = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [7:0]  wr_data;
    logic        wr_en;
    logic [7:0]  rd_data;
    logic        hit;
    logic        miss;

    fully_associative_cache dut (
        .clk     (clk),
        .reset   (reset),
        .addr    (addr),
        .wr_data (wr_data),
        .wr_en   (wr_en),
        .rd_data (rd_data),
        .hit     (hit),
        .miss    (miss)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    bit          m_valid [NW];
    int unsigned m_tag   [NW];
    byte unsigned m_data [NW][BS];
    int          m_ptr;
    int          m_rec[$];   // recency order, front = least recent

    task automatic model_reset();
        for (int w = 0; w < NW; w++) m_valid[w] = 1'b0;
        m_ptr = 0;
        m_rec.delete();
        for (int w = 0; w < NW; w++) m_rec.push_back(w);
    endtask

    task automatic model_touch(input int w);
        for (int i = 0; i < m_rec.size(); i++) begin
            if (m_rec[i] == w) begin
                m_rec.delete(i);
                break;
            end
        end
        m_rec.push_back(w);
    endtask

    task automatic model_access(input logic [31:0] a, input logic wr, input logic [7:0] d,
                                output bit h, output logic [7:0] r);
        int unsigned tag;
        int off;
        int w;
        tag = a >> 4;
        off = int'(a & 32'hF);
        w = -1;
        for (int i = 0; i < NW; i++) if (m_valid[i] && m_tag[i] == tag) w = i;
        h = (w >= 0);
        if (!h) begin
`ifdef FA_CACHE_LRU_EN
            for (int i = NW - 1; i >= 0; i--) if (!m_valid[i]) w = i;
            if (w < 0) w = m_rec[0];
`else
            w = m_ptr;
            m_ptr = (m_ptr + 1) % NW;
`endif
            m_valid[w] = 1'b1;
            m_tag[w]   = tag;
            for (int b = 0; b < BS; b++) m_data[w][b] = 8'h00;
        end
        if (wr) m_data[w][off] = d;
        r = m_data[w][off];
        model_touch(w);
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One access: drive, advance one edge, sample 1 time unit later.
    task automatic apply(input logic [31:0] a, input logic w, input logic [7:0] d,
                         output logic h, output logic m, output logic [7:0] r,
                         output bit mh, output logic [7:0] mr);
        addr    = a;
        wr_en   = w;
        wr_data = d;
        model_access(a, w, d, mh, mr);
        @(posedge clk);
        #1;
        h = hit;
        m = miss;
        r = rd_data;
        $display("txn addr=%08h wr=%0b data=%02h -> hit=%0b miss=%0b rd=%02h",
                 a, w, d, h, m, r);
    endtask

    task automatic do_reset(input logic [31:0] a, input logic w);
        reset   = 1'b1;
        addr    = a;
        wr_en   = w;
        wr_data = 8'h5A;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        $display("txn reset -> hit=%0b miss=%0b rd=%02h", hit, miss, rd_data);
        check("reset_hit",  hit,     0);
        check("reset_miss", miss,    0);
        check("reset_rd",   rd_data, 0);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [7:0]  data;
        logic        exp_hit;
        logic [7:0]  exp_rd;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic        h, m;
        logic [7:0]  r, mr;
        bit          mh;
        logic [31:0] a;
        logic        w;
        logic [7:0]  d;

        reset   = 1'b1;
        addr    = '0;
        wr_en   = 1'b0;
        wr_data = '0;
        @(posedge clk);
        do_reset(32'h0000_1234, 1'b1);

        // ---- directed vector table ----
        for (int i = 0; i < 16; i++)
            vecs.push_back('{32'h1000 + i * 160, 1'b1, 8'(8'hAA + i), 1'b0, 8'(8'hAA + i)});
        for (int i = 0; i < 16; i++)
            vecs.push_back('{32'h1000 + i * 160, 1'b0, 8'h00, 1'b1, 8'(8'hAA + i)});
        vecs.push_back('{32'h0000_FFFF, 1'b1, 8'hFF, 1'b0, 8'hFF});   // evicts way 0
        vecs.push_back('{32'h0000_1000, 1'b0, 8'h00, 1'b0, 8'h00});   // evicts way 1
        vecs.push_back('{32'h0000_FFFF, 1'b0, 8'h00, 1'b1, 8'hFF});
        vecs.push_back('{32'h0000_10A0, 1'b0, 8'h00, 1'b0, 8'h00});   // way 1 was evicted
        vecs.push_back('{32'h0000_2000, 1'b1, 8'h10, 1'b0, 8'h10});
        vecs.push_back('{32'h0000_2001, 1'b1, 8'h11, 1'b1, 8'h11});
        vecs.push_back('{32'h0000_200F, 1'b1, 8'h1F, 1'b1, 8'h1F});
        vecs.push_back('{32'h0000_2000, 1'b0, 8'h00, 1'b1, 8'h10});
        vecs.push_back('{32'h0000_2001, 1'b0, 8'h00, 1'b1, 8'h11});
        vecs.push_back('{32'h0000_200F, 1'b0, 8'h00, 1'b1, 8'h1F});
        vecs.push_back('{32'h0000_2005, 1'b0, 8'h00, 1'b1, 8'h00});   // zeroed on allocation
        for (int i = 0; i < 32; i++)
            vecs.push_back('{32'h0001_0000 + i * 16, 1'b0, 8'h00, 1'b0, 8'h00});
        vecs.push_back('{32'h0001_0000, 1'b0, 8'h00, 1'b0, 8'h00});   // evicted by the sweep

        foreach (vecs[i]) begin
            apply(vecs[i].addr, vecs[i].wr, vecs[i].data, h, m, r, mh, mr);
            check($sformatf("vec%0d_hit", i),  h, vecs[i].exp_hit);
            check($sformatf("vec%0d_miss", i), m, !vecs[i].exp_hit);
            check($sformatf("vec%0d_rd", i),   r, vecs[i].exp_rd);
        end

        // ---- same address held for consecutive edges ----
        apply(32'h0000_3004, 1'b0, 8'h00, h, m, r, mh, mr);
        check("hold_first_miss", m, 1);
        apply(32'h0000_3004, 1'b0, 8'h00, h, m, r, mh, mr);
        check("hold_second_hit", h, 1);
        apply(32'h0000_3004, 1'b1, 8'h77, h, m, r, mh, mr);
        check("hold_third_hit", h, 1);
        check("hold_third_rd",  r, 8'h77);
        apply(32'h0000_3004, 1'b0, 8'h00, h, m, r, mh, mr);
        check("hold_readback", r, 8'h77);

        // ---- reset mid-sequence, with a write pending on the reset edge ----
        do_reset(32'h0000_2000, 1'b1);
        apply(32'h0000_2000, 1'b0, 8'h00, h, m, r, mh, mr);
        check("post_reset_miss", m, 1);
        check("post_reset_rd",   r, 8'h00);
        apply(32'h0000_2000, 1'b0, 8'h00, h, m, r, mh, mr);
        check("post_reset_hit", h, 1);
        check("post_reset_rd2", r, 8'h00);

        // ---- random accesses against the model: 24 tags over 16 lines ----
        for (int n = 0; n < 400; n++) begin
            a = 32'h0004_0000 + (32'($urandom_range(0, 23)) << 4) + 32'($urandom_range(0, 15));
            w = 1'($urandom_range(0, 1));
            d = 8'($urandom);
            apply(a, w, d, h, m, r, mh, mr);
            check($sformatf("rnd%0d_hit", n),  h, mh);
            check($sformatf("rnd%0d_miss", n), m, !mh);
            check($sformatf("rnd%0d_rd", n),   r, mr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
